msa_null_counter: RTL and testbench

//  Multi-channel digital nulling loop: closes the loop around the main summing amp error detectors.
//  Per channel, it reads the coarse/fine Schmitt error outputs and servos a modular angle read counter.
//  Its low bits drive the active-low fine ladder switches (D15..D21 style) back into the summing amp.

---
 rtl/msa_null_counter.sv | 237 +++++++++++++++++++++++
 tb/tb_msa_null_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/msa_null_counter.sv
// Multi-channel digital nulling loop: per-channel modular read counters servoed from the
// coarse/fine error detectors, registered ladder drive, and a round-robin increment-pulse emitter.
module msa_null_counter #(
    parameter int NCH          = 3,
    parameter int WIDTH        = 16,
    parameter int LADDER_BITS  = 7,
    parameter int COARSE_SHIFT = 4,
    parameter int PEND_W       = 8,
    localparam int CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic [NCH-1:0]         err_sign,
    input  logic [NCH-1:0]         err_fine,
    input  logic [NCH-1:0]         err_coarse,
    input  logic [NCH-1:0]         zero_req,
    input  logic [CHW-1:0]         ch_sel,
    output logic [LADDER_BITS-1:0] ladder_n,
    output logic [NCH*WIDTH-1:0]   count_out,
    output logic [NCH*2-1:0]       mode,
    output logic [NCH-1:0]         ovf,
    output logic                   pulse_valid,
    output logic [CHW-1:0]         pulse_ch,
    output logic                   pulse_dir,
    input  logic                   pulse_ready
);

    typedef enum logic [1:0] {
        MODE_NULL   = 2'b00,
        MODE_FINE   = 2'b01,
        MODE_COARSE = 2'b10
    } mode_e;

    // Headroom so pending + coarse step + accept never wraps before saturation.
    localparam int SW = PEND_W + COARSE_SHIFT + 2;
    localparam logic signed [SW-1:0] PEND_MAX    = SW'((32'sd1 <<< (PEND_W - 1)) - 32'sd1);
    localparam logic signed [SW-1:0] PEND_MIN    = -PEND_MAX;
    localparam logic signed [SW-1:0] ONE_S       = SW'(32'sd1);
    localparam logic signed [SW-1:0] ZERO_S      = SW'(32'sd0);
    localparam logic signed [SW-1:0] PEND_COARSE = SW'(32'sd1 <<< COARSE_SHIFT);
    localparam logic [WIDTH-1:0]     CNT_ONE     = WIDTH'(32'd1);
    localparam logic [WIDTH-1:0]     CNT_COARSE  = WIDTH'(32'd1 << COARSE_SHIFT);

    function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [SW-1:0] v);
        logic signed [PEND_W-1:0] r;
        if (v > PEND_MAX) begin
            r = PEND_MAX[PEND_W-1:0];
        end else if (v < PEND_MIN) begin
            r = PEND_MIN[PEND_W-1:0];
        end else begin
            r = v[PEND_W-1:0];
        end
        return r;
    endfunction

    function automatic logic is_clipped(input logic signed [SW-1:0] v);
        return (v > PEND_MAX) || (v < PEND_MIN);
    endfunction

    function automatic logic [CHW-1:0] next_ch(input logic [CHW-1:0] c);
        logic [CHW-1:0] r;
        if (c == CHW'(NCH - 1)) begin
            r = {CHW{1'b0}};
        end else begin
            r = c + {{(CHW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [WIDTH-1:0]         count_r     [NCH];
    mode_e                    mode_r      [NCH];
    logic signed [PEND_W-1:0] pend_r      [NCH];
    logic [NCH-1:0]           ovf_r;
    logic [CHW-1:0]           rr_r;
    logic [CHW-1:0]           emit_ptr_r;
    logic                     pulse_valid_r;
    logic [CHW-1:0]           pulse_ch_r;
    logic                     pulse_dir_r;
    logic [LADDER_BITS-1:0]   ladder_r;

    logic [WIDTH-1:0]         count_nxt_s [NCH];
    mode_e                    mode_nxt_s  [NCH];
    logic signed [PEND_W-1:0] pend_nxt_s  [NCH];
    logic [NCH-1:0]           ovf_nxt_s;
    logic [NCH-1:0]           svc_s;
    logic [NCH-1:0]           acc_s;
    logic [WIDTH-1:0]         cnt_step_s  [NCH];
    logic signed [SW-1:0]     pend_step_s [NCH];
    logic signed [SW-1:0]     pend_ext_s  [NCH];
    logic signed [SW-1:0]     sum_s       [NCH];
    logic                     accept_s;
    logic                     found_s;
    logic [CHW-1:0]           pick_s;
    int                       idx_s;
    logic [LADDER_BITS-1:0]   ladder_nxt_s;

    assign accept_s = pulse_valid_r & pulse_ready;

    // Per-channel service step, counter update and pending-pulse accounting.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            svc_s[c]       = tick && (rr_r == CHW'(c));
            acc_s[c]       = accept_s && (pulse_ch_r == CHW'(c));
            cnt_step_s[c]  = {WIDTH{1'b0}};
            pend_step_s[c] = ZERO_S;
            pend_ext_s[c]  = pend_r[c];
            sum_s[c]       = pend_ext_s[c];
            count_nxt_s[c] = count_r[c];
            mode_nxt_s[c]  = mode_r[c];
            pend_nxt_s[c]  = pend_r[c];
            ovf_nxt_s[c]   = ovf_r[c];
            if (svc_s[c] && zero_req[c]) begin
                // A same-cycle accept is simply absorbed: the channel is cleared outright.
                count_nxt_s[c] = {WIDTH{1'b0}};
                mode_nxt_s[c]  = MODE_NULL;
                pend_nxt_s[c]  = {PEND_W{1'b0}};
            end else begin
                if (svc_s[c]) begin
                    case ({err_coarse[c], err_fine[c]})
                        2'b10, 2'b11: begin
                            mode_nxt_s[c]  = MODE_COARSE;
                            cnt_step_s[c]  = CNT_COARSE;
                            pend_step_s[c] = PEND_COARSE;
                        end
                        2'b01: begin
                            mode_nxt_s[c]  = MODE_FINE;
                            cnt_step_s[c]  = CNT_ONE;
                            pend_step_s[c] = ONE_S;
                        end
                        default: begin
                            mode_nxt_s[c]  = MODE_NULL;
                            cnt_step_s[c]  = {WIDTH{1'b0}};
                            pend_step_s[c] = ZERO_S;
                        end
                    endcase
                    count_nxt_s[c] = err_sign[c] ? (count_r[c] + cnt_step_s[c])
                                                 : (count_r[c] - cnt_step_s[c]);
                end else begin
                    count_nxt_s[c] = count_r[c];
                end
                sum_s[c] = pend_ext_s[c]
                         + (err_sign[c] ? pend_step_s[c] : -pend_step_s[c])
                         - (acc_s[c] ? (pulse_dir_r ? ONE_S : -ONE_S) : ZERO_S);
                pend_nxt_s[c] = sat_pend(sum_s[c]);
                ovf_nxt_s[c]  = ovf_r[c] | is_clipped(sum_s[c]);
            end
        end
    end

    // Round-robin search from the emit pointer; descending loop so the nearest channel wins.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {CHW{1'b0}};
        idx_s   = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx_s = int'(emit_ptr_r) + k;
            idx_s = (idx_s >= NCH) ? (idx_s - NCH) : idx_s;
            if (pend_r[idx_s] != {PEND_W{1'b0}}) begin
                found_s = 1'b1;
                pick_s  = CHW'(idx_s);
            end else begin
                found_s = found_s;
                pick_s  = pick_s;
            end
        end
    end

    // Ladder source; an out-of-range selection leaves every tap off.
    always_comb begin
        if (ch_sel <= CHW'(NCH - 1)) begin
            ladder_nxt_s = ~count_r[ch_sel][LADDER_BITS-1:0];
        end else begin
            ladder_nxt_s = {LADDER_BITS{1'b1}};
        end
    end

    // State registers: channel state, service pointer, emitter handshake and ladder drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                count_r[c] <= {WIDTH{1'b0}};
                mode_r[c]  <= MODE_NULL;
                pend_r[c]  <= {PEND_W{1'b0}};
            end
            ovf_r         <= {NCH{1'b0}};
            rr_r          <= {CHW{1'b0}};
            emit_ptr_r    <= {CHW{1'b0}};
            pulse_valid_r <= 1'b0;
            pulse_ch_r    <= {CHW{1'b0}};
            pulse_dir_r   <= 1'b0;
            ladder_r      <= {LADDER_BITS{1'b1}};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                count_r[c] <= count_nxt_s[c];
                mode_r[c]  <= mode_nxt_s[c];
                pend_r[c]  <= pend_nxt_s[c];
            end
            ovf_r    <= ovf_nxt_s;
            ladder_r <= ladder_nxt_s;
            if (tick) begin
                rr_r <= next_ch(rr_r);
            end else begin
                rr_r <= rr_r;
            end
            if (pulse_valid_r) begin
                // Offered pulse is frozen until the consumer takes it.
                if (pulse_ready) begin
                    pulse_valid_r <= 1'b0;
                    emit_ptr_r    <= next_ch(pulse_ch_r);
                end else begin
                    pulse_valid_r <= 1'b1;
                end
            end else if (found_s) begin
                pulse_valid_r <= 1'b1;
                pulse_ch_r    <= pick_s;
                pulse_dir_r   <= ~pend_r[pick_s][PEND_W-1];
            end else begin
                pulse_valid_r <= 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_out
            assign count_out[g*WIDTH +: WIDTH] = count_r[g];
            assign mode[g*2 +: 2]              = mode_r[g];
        end
    endgenerate

    assign ovf         = ovf_r;
    assign ladder_n    = ladder_r;
    assign pulse_valid = pulse_valid_r;
    assign pulse_ch    = pulse_ch_r;
    assign pulse_dir   = pulse_dir_r;

endmodule

// File: tb/tb_msa_null_counter.sv
// Directed bench for msa_null_counter (NCH=3, WIDTH=16, LADDER_BITS=7, COARSE_SHIFT=4, PEND_W=8).
module tb_msa_null_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [2:0]  err_sign, err_fine, err_coarse, zero_req;
    logic [1:0]  ch_sel;
    logic [6:0]  ladder_n;
    logic [47:0] count_out;
    logic [5:0]  mode;
    logic [2:0]  ovf;
    logic        pulse_valid;
    logic [1:0]  pulse_ch;
    logic        pulse_dir;
    logic        pulse_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int rr_m     = 0;

    msa_null_counter dut (
        .clk(clk), .rst(rst), .tick(tick), .err_sign(err_sign), .err_fine(err_fine),
        .err_coarse(err_coarse), .zero_req(zero_req), .ch_sel(ch_sel), .ladder_n(ladder_n),
        .count_out(count_out), .mode(mode), .ovf(ovf), .pulse_valid(pulse_valid),
        .pulse_ch(pulse_ch), .pulse_dir(pulse_dir), .pulse_ready(pulse_ready)
    );

    always #5 clk = ~clk;

    // Tick until channel c has been served (at most 3 ticks), tracking the service pointer.
    task automatic service_ch(input int c);
        int served;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            served = rr_m;
            @(negedge clk);
            tick = 1'b0;
            rr_m = (rr_m + 1) % 3;
            if (served == c) break;
        end
    endtask

    // Accept with ready=1 until the pulse stream has been idle for 12 cycles.
    task automatic collect_pulses(input logic [1:0] exp_ch, input logic exp_dir,
                                  input int exp_n, input string tag);
        int got, bad, idle, cyc;
        got = 0; bad = 0; idle = 0; cyc = 0;
        pulse_ready = 1'b1;
        while (cyc < 2000 && idle < 12) begin
            if (pulse_valid === 1'b1) begin
                got++;
                idle = 0;
                if (pulse_ch !== exp_ch || pulse_dir !== exp_dir) bad++;
            end else begin
                idle++;
            end
            @(negedge clk);
            cyc++;
        end
        pulse_ready = 1'b0;
        n_checks++; if (got !== exp_n) begin n_fail++; $display("FAIL %s_count: got %0d expected %0d", tag, got, exp_n); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL %s_chdir: %0d pulses with wrong ch/dir, expected 0", tag, bad); end
        n_checks++; if (idle < 12) begin n_fail++; $display("FAIL %s_timeout: stream not idle after %0d cycles", tag, cyc); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rr_m = 0;
        repeat (20) @(negedge clk);
        n_checks++; if (count_out !== 48'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", count_out); end
        n_checks++; if (mode !== 6'b0) begin n_fail++; $display("FAIL reset_mode: got %b expected 000000", mode); end
        n_checks++; if (ladder_n !== 7'h7F) begin n_fail++; $display("FAIL reset_ladder: got %h expected 7f", ladder_n); end
        n_checks++; if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", pulse_valid); end
        n_checks++; if (ovf !== 3'b000) begin n_fail++; $display("FAIL reset_ovf: got %b expected 000", ovf); end
    endtask

    task automatic test_fine_plus();
        pulse_ready = 1'b0;
        err_fine = 3'b001; err_sign = 3'b001;
        repeat (5) service_ch(0);
        err_fine = 3'b000; err_sign = 3'b000;
        n_checks++; if (count_out[15:0] !== 16'd5) begin n_fail++; $display("FAIL fine_count0: got %h expected 0005", count_out[15:0]); end
        n_checks++; if (mode[1:0] !== 2'b01) begin n_fail++; $display("FAIL fine_mode0: got %b expected 01", mode[1:0]); end
        n_checks++; if (ladder_n !== 7'h7B) begin n_fail++; $display("FAIL fine_ladder_lag: got %h expected 7b", ladder_n); end
        @(negedge clk);
        n_checks++; if (ladder_n !== 7'h7A) begin n_fail++; $display("FAIL fine_ladder: got %h expected 7a", ladder_n); end
        n_checks++; if ({pulse_valid, pulse_ch, pulse_dir} !== 4'b1_00_1) begin n_fail++; $display("FAIL fine_offer: got v%b ch%0d d%b expected v1 ch0 d1", pulse_valid, pulse_ch, pulse_dir); end
        collect_pulses(2'd0, 1'b1, 5, "fine_pulses");
    endtask

    task automatic test_coarse_minus();
        pulse_ready = 1'b0;
        err_coarse = 3'b010; err_sign = 3'b000;
        service_ch(1);
        err_coarse = 3'b000;
        n_checks++; if (count_out[31:16] !== 16'hFFF0) begin n_fail++; $display("FAIL coarse_count1: got %h expected fff0", count_out[31:16]); end
        n_checks++; if (mode[3:2] !== 2'b10) begin n_fail++; $display("FAIL coarse_mode1: got %b expected 10", mode[3:2]); end
        n_checks++; if (ovf !== 3'b000) begin n_fail++; $display("FAIL coarse_wrap_ovf: got %b expected 000", ovf); end
        n_checks++; if (ladder_n !== 7'h7A) begin n_fail++; $display("FAIL coarse_ladder_pre: got %h expected 7a", ladder_n); end
        ch_sel = 2'd1;
        @(negedge clk);
        n_checks++; if (ladder_n !== 7'h0F) begin n_fail++; $display("FAIL coarse_ladder_sel: got %h expected 0f", ladder_n); end
        ch_sel = 2'd0;
        collect_pulses(2'd1, 1'b0, 16, "coarse_pulses");
    endtask

    task automatic test_saturate();
        pulse_ready = 1'b0;
        err_coarse = 3'b100; err_sign = 3'b100;
        repeat (10) service_ch(2);
        err_coarse = 3'b000; err_sign = 3'b000;
        @(negedge clk);
        n_checks++; if (count_out[47:32] !== 16'h00A0) begin n_fail++; $display("FAIL sat_count2: got %h expected 00a0", count_out[47:32]); end
        n_checks++; if (ovf !== 3'b100) begin n_fail++; $display("FAIL sat_ovf: got %b expected 100", ovf); end
        n_checks++; if ({pulse_valid, pulse_ch, pulse_dir} !== 4'b1_10_1) begin n_fail++; $display("FAIL sat_offer: got v%b ch%0d d%b expected v1 ch2 d1", pulse_valid, pulse_ch, pulse_dir); end
        collect_pulses(2'd2, 1'b1, 127, "sat_pulses");
        n_checks++; if (ovf !== 3'b100) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b expected 100", ovf); end
    endtask

    task automatic test_zero_accept();
        pulse_ready = 1'b0;
        err_fine = 3'b001; err_sign = 3'b001;
        repeat (3) service_ch(0);
        err_fine = 3'b000; err_sign = 3'b000;
        n_checks++; if (count_out[15:0] !== 16'd8) begin n_fail++; $display("FAIL zero_pre_count0: got %h expected 0008", count_out[15:0]); end
        service_ch(1);
        service_ch(2);
        n_checks++; if ({pulse_valid, pulse_ch} !== 3'b1_00) begin n_fail++; $display("FAIL zero_pre_offer: got v%b ch%0d expected v1 ch0", pulse_valid, pulse_ch); end
        zero_req = 3'b001;
        pulse_ready = 1'b1;
        service_ch(0);
        zero_req = 3'b000;
        pulse_ready = 1'b0;
        n_checks++; if (count_out[15:0] !== 16'd0) begin n_fail++; $display("FAIL zero_count0: got %h expected 0000", count_out[15:0]); end
        n_checks++; if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b expected 0", pulse_valid); end
        n_checks++; if (mode[1:0] !== 2'b00) begin n_fail++; $display("FAIL zero_mode0: got %b expected 00", mode[1:0]); end
        n_checks++; if (ovf !== 3'b100) begin n_fail++; $display("FAIL zero_ovf_kept: got %b expected 100", ovf); end
        collect_pulses(2'd0, 1'b1, 0, "zero_no_pulses");
    endtask

    task automatic test_reset_midop();
        pulse_ready = 1'b0;
        err_fine = 3'b010; err_sign = 3'b000;
        service_ch(1);
        err_fine = 3'b000;
        n_checks++; if (count_out[31:16] !== 16'hFFEF) begin n_fail++; $display("FAIL midrst_count1: got %h expected ffef", count_out[31:16]); end
        @(negedge clk);
        n_checks++; if ({pulse_valid, pulse_ch, pulse_dir} !== 4'b1_01_0) begin n_fail++; $display("FAIL midrst_offer: got v%b ch%0d d%b expected v1 ch1 d0", pulse_valid, pulse_ch, pulse_dir); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr_m = 0;
        n_checks++; if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", pulse_valid); end
        n_checks++; if (count_out !== 48'h0) begin n_fail++; $display("FAIL midrst_count: got %h expected 0", count_out); end
        n_checks++; if ({mode, ovf} !== 9'b0) begin n_fail++; $display("FAIL midrst_mode_ovf: got %b/%b expected 0/0", mode, ovf); end
        n_checks++; if (ladder_n !== 7'h7F) begin n_fail++; $display("FAIL midrst_ladder: got %h expected 7f", ladder_n); end
        repeat (5) @(negedge clk);
        n_checks++; if (pulse_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_pending_cleared: got %b expected 0", pulse_valid); end
        err_fine = 3'b001; err_sign = 3'b001;
        service_ch(0);
        err_fine = 3'b000; err_sign = 3'b000;
        n_checks++; if (count_out[15:0] !== 16'd1) begin n_fail++; $display("FAIL midrst_rr: got %h expected 0001", count_out[15:0]); end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; err_sign = 3'b000; err_fine = 3'b000; err_coarse = 3'b000;
        zero_req = 3'b000; ch_sel = 2'd0; pulse_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_fine_plus();
        test_coarse_minus();
        test_saturate();
        test_zero_accept();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
